dual_issue_dispatcher: RTL and testbench
========================================

# dual_issue_dispatcher

In-order dual-issue dispatcher between the instruction buffer and the execute stage. It examines the two oldest buffer entries each cycle and decides how many to issue: zero, entry0 alone, or entry0 and entry1 together. It returns pop0/pop1 to the buffer and registers the issued instructions into two slot registers. A load scoreboard tracks outstanding load destinations so consumers wait until writeback.

## Interface
- XLEN, 32: instruction and address width.
- NREGS, 32: architectural register count; scoreboard width.

- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  pipeline redirect; kills slot registers.
- entry0_instruction / entry0_address  in  XLEN each  oldest buffer entry.
- entry1_instruction / entry1_address  in  XLEN each  second-oldest entry.
- entry_count  in  4  valid entries in the buffer (0–4).
- issue_ready  in  1  execute stage accepts the slot registers this cycle.
- wb_valid  in  1  load writeback occurring.
- wb_rd  in  5  load writeback destination.
- pop0  out  1  entry0 consumed this cycle (combinational).
- pop1  out  1  entry1 consumed this cycle (combinational); never high without pop0.
- slot0_valid, slot0_instr, slot0_pc  out  1/XLEN/XLEN  registered issue slot 0.
- slot1_valid, slot1_instr, slot1_pc  out  1/XLEN/XLEN  registered issue slot 1.
- sb_busy  out  NREGS  scoreboard; bit r set while a load to xr is outstanding.

## Operation
- Decode fields: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Register read/write classes:
  - rs1 is read by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is read by OP (0110011), STORE (0100011) and BRANCH (1100011).
  - rd is written by every opcode except STORE, BRANCH and MISC-MEM (0001111).
  - x0 is never a hazard source or target.
- Scoreboard hazard for an instruction: any used rs, or a written rd, has its sb_busy bit set.
- Issue of entry0 (can0) requires all of:
  - entry_count ≥ 1, issue_ready = 1, flush = 0;
  - no scoreboard hazard on entry0.
- Issue of entry1 (can1) requires all of:
  - can0, and entry_count ≥ 2;
  - entry1 is ALU class (OP, OP-IMM 0010011, LUI, AUIPC);
  - entry0 is not BRANCH, JAL, JALR (1100111) or SYSTEM (1110011);
  - entry1 reads no register that entry0 writes;
  - entry1 does not write the same rd as entry0;
  - no scoreboard hazard on entry1.
- Outputs: pop0 = can0; pop1 = can1.
- Slot registers, when issue_ready = 1 and flush = 0:
  - slot0 ← {can0, entry0};
  - slot1 ← {can1, entry1};
  - instr and pc fields of invalid slots are zeroed.
- Scoreboard update each cycle:
  - set the rd bit of each issued LOAD (0000011) with rd ≠ 0;
  - clear the wb_rd bit when wb_valid = 1;
  - if set and clear hit the same bit in the same cycle, set wins.
- Flush: both slot valid bits clear, pop0 = pop1 = 0 that cycle, scoreboard unaffected (issued loads still write back).

## Timing
- Reset (asynchronous): all slot outputs 0, sb_busy = 0, perf counters 0. pop0/pop1 are 0 while rst is high.
- pop0/pop1 are combinational from the current entries, entry_count, issue_ready, flush and sb_busy (the registered value, before this cycle's updates).
- An issued instruction appears in a slot register one cycle after its pop.
- issue_ready = 0: slot registers hold their value, pops are 0, scoreboard clears still apply.
- Writeback latency: wb_valid for xr at cycle N clears the bit at edge N+1. A consumer of xr pops at N+1 at the earliest; there is no same-cycle bypass through the scoreboard.
- entry_count = 1: pop1 is always 0. entry_count = 0: both pops are 0.
- Flush together with issue_ready = 1: flush dominates.

## Configuration
- DISPATCH_PERF_EN defined: adds two 32-bit outputs, both wrapping on overflow:
  - perf_dual_issue increments each cycle pop1 = 1;
  - perf_stall increments each cycle with entry_count ≥ 1 and pop0 = 0.
- DISPATCH_PERF_EN undefined: neither port nor the counters exist. Dispatch behaviour is identical in both builds.

## Test plan
- Independent pair: entry0 = addi x1,x0,5; entry1 = add x2,x3,x4; count = 2; issue_ready = 1 → pop0 = pop1 = 1; next cycle slot0_valid = slot1_valid = 1 with matching pcs.
- Intra-pair RAW: entry0 = addi x5,x0,1; entry1 = add x6,x5,x5 → pop0 = 1, pop1 = 0; next cycle with entry1 now in entry0 → pop0 = 1.
- Load-use: issue lw x7,0(x1) → sb_busy[7] = 1. Following add x8,x7,x0 is blocked until wb_valid = 1, wb_rd = 7 at cycle N; it pops at N+1.
- Set/clear collision: wb_valid = 1, wb_rd = 9 in the same cycle lw x9 issues → sb_busy[9] stays 1.
- Backpressure/flush:
  - issue_ready = 0 for 3 cycles → pops 0, slots hold;
  - flush = 1 with issue_ready = 1 → slot valids 0 next cycle, sb_busy unchanged.
- Reset mid-operation: rst asserted asynchronously with slots valid and sb_busy ≠ 0 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dual_issue_dispatcher.sv
// dual_issue_dispatcher
//   In-order dual-issue dispatcher. Looks at the two oldest instruction
//   buffer entries, decides whether to issue none, entry0 alone, or both,
//   returns pop0/pop1 to the buffer and registers the issued instructions
//   into two slot registers. A load scoreboard holds consumers of an
//   outstanding load destination until its writeback.
//
//   Optional feature macro: DISPATCH_PERF_EN
//     defined   -> perf_dual_issue / perf_stall 32-bit wrapping counters
//     undefined -> neither port nor counters exist
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    redirect; kills slot valids, blocks pops
//   entry0_*/entry1_*        oldest / second-oldest buffer entries
//   entry_count              valid entries in buffer (0-4)
//   issue_ready              execute stage accepts the slots this cycle
//   wb_valid, wb_rd          load writeback clearing a scoreboard bit
//   pop0, pop1               entries consumed this cycle (combinational)
//   slot0_*/slot1_*          registered issue slots
//   sb_busy                  outstanding-load scoreboard
//   perf_dual_issue/_stall   performance counters (DISPATCH_PERF_EN only)
module dual_issue_dispatcher #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [XLEN-1:0]  entry0_instruction,
  input  logic [XLEN-1:0]  entry0_address,
  input  logic [XLEN-1:0]  entry1_instruction,
  input  logic [XLEN-1:0]  entry1_address,
  input  logic [3:0]       entry_count,
  input  logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             pop0,
  output logic             pop1,
  output logic             slot0_valid,
  output logic [XLEN-1:0]  slot0_instr,
  output logic [XLEN-1:0]  slot0_pc,
  output logic             slot1_valid,
  output logic [XLEN-1:0]  slot1_instr,
  output logic [XLEN-1:0]  slot1_pc,
`ifdef DISPATCH_PERF_EN
  output logic [31:0]      perf_dual_issue,
  output logic [31:0]      perf_stall,
`endif
  output logic [NREGS-1:0] sb_busy
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return !(op == OPC_STORE || op == OPC_BRANCH || op == OPC_MISC);
  endfunction

  function automatic logic is_alu(input logic [6:0] op);
    return (op == OPC_OP || op == OPC_OPIMM || op == OPC_LUI || op == OPC_AUIPC);
  endfunction

  function automatic logic ends_group(input logic [6:0] op);
    return (op == OPC_BRANCH || op == OPC_JAL || op == OPC_JALR || op == OPC_SYSTEM);
  endfunction

  logic [6:0] op0, op1;
  logic [4:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
  logic       use_rs1_0, use_rs2_0, wr_rd0, use_rs1_1, use_rs2_1, wr_rd1;
  logic       haz0, haz1, raw01, waw01, can0, can1;
  logic [NREGS-1:0] sb_set, sb_clr;

  assign op0   = entry0_instruction[6:0];
  assign rd0   = entry0_instruction[11:7];
  assign rs1_0 = entry0_instruction[19:15];
  assign rs2_0 = entry0_instruction[24:20];
  assign op1   = entry1_instruction[6:0];
  assign rd1   = entry1_instruction[11:7];
  assign rs1_1 = entry1_instruction[19:15];
  assign rs2_1 = entry1_instruction[24:20];

  // x0 references are folded into the "use" qualifiers so they never hazard.
  assign use_rs1_0 = reads_rs1(op0) && (rs1_0 != 5'd0);
  assign use_rs2_0 = reads_rs2(op0) && (rs2_0 != 5'd0);
  assign wr_rd0    = writes_rd(op0) && (rd0 != 5'd0);
  assign use_rs1_1 = reads_rs1(op1) && (rs1_1 != 5'd0);
  assign use_rs2_1 = reads_rs2(op1) && (rs2_1 != 5'd0);
  assign wr_rd1    = writes_rd(op1) && (rd1 != 5'd0);

  assign haz0 = (use_rs1_0 && sb_busy[rs1_0]) || (use_rs2_0 && sb_busy[rs2_0]) ||
                (wr_rd0 && sb_busy[rd0]);
  assign haz1 = (use_rs1_1 && sb_busy[rs1_1]) || (use_rs2_1 && sb_busy[rs2_1]) ||
                (wr_rd1 && sb_busy[rd1]);

  assign raw01 = wr_rd0 && ((use_rs1_1 && rs1_1 == rd0) || (use_rs2_1 && rs2_1 == rd0));
  assign waw01 = wr_rd0 && wr_rd1 && (rd1 == rd0);

  // rst gates the pops so the buffer is never popped during reset.
  assign can0 = !rst && (entry_count != 4'd0) && issue_ready && !flush && !haz0;
  assign can1 = can0 && (entry_count >= 4'd2) && is_alu(op1) && !ends_group(op0) &&
                !raw01 && !waw01 && !haz1;

  assign pop0 = can0;
  assign pop1 = can1;

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (can0 && op0 == OPC_LOAD && rd0 != 5'd0) sb_set[rd0] = 1'b1;
    if (can1 && op1 == OPC_LOAD && rd1 != 5'd0) sb_set[rd1] = 1'b1;
    if (wb_valid) sb_clr[wb_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_busy <= '0;
    end else begin
      // set applied after clear so a same-cycle collision leaves the bit set
      sb_busy <= (sb_busy & ~sb_clr) | sb_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_valid <= 1'b0;
      slot0_instr <= '0;
      slot0_pc    <= '0;
      slot1_valid <= 1'b0;
      slot1_instr <= '0;
      slot1_pc    <= '0;
    end else if (flush) begin
      slot0_valid <= 1'b0;
      slot0_instr <= '0;
      slot0_pc    <= '0;
      slot1_valid <= 1'b0;
      slot1_instr <= '0;
      slot1_pc    <= '0;
    end else if (issue_ready) begin
      slot0_valid <= can0;
      slot0_instr <= can0 ? entry0_instruction : '0;
      slot0_pc    <= can0 ? entry0_address     : '0;
      slot1_valid <= can1;
      slot1_instr <= can1 ? entry1_instruction : '0;
      slot1_pc    <= can1 ? entry1_address     : '0;
    end
  end

`ifdef DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dual_issue <= '0;
      perf_stall      <= '0;
    end else begin
      if (pop1) perf_dual_issue <= perf_dual_issue + 32'd1;
      if (entry_count != 4'd0 && !pop0) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_dispatcher.sv
// Directed testbench for dual_issue_dispatcher: hand-built instruction
// encodings, hand-computed expectations checked with immediate assertions.
module tb_dual_issue_dispatcher;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [XLEN-1:0]  entry0_instruction, entry0_address;
  logic [XLEN-1:0]  entry1_instruction, entry1_address;
  logic [3:0]       entry_count;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             pop0, pop1;
  logic             slot0_valid, slot1_valid;
  logic [XLEN-1:0]  slot0_instr, slot0_pc, slot1_instr, slot1_pc;
  logic [NREGS-1:0] sb_busy;
`ifdef DISPATCH_PERF_EN
  logic [31:0]      perf_dual_issue, perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  dual_issue_dispatcher #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .entry0_instruction (entry0_instruction),
    .entry0_address     (entry0_address),
    .entry1_instruction (entry1_instruction),
    .entry1_address     (entry1_address),
    .entry_count        (entry_count),
    .issue_ready        (issue_ready),
    .wb_valid           (wb_valid),
    .wb_rd              (wb_rd),
    .pop0               (pop0),
    .pop1               (pop1),
    .slot0_valid        (slot0_valid),
    .slot0_instr        (slot0_instr),
    .slot0_pc           (slot0_pc),
    .slot1_valid        (slot1_valid),
    .slot1_instr        (slot1_instr),
    .slot1_pc           (slot1_pc),
`ifdef DISPATCH_PERF_EN
    .perf_dual_issue    (perf_dual_issue),
    .perf_stall         (perf_stall),
`endif
    .sb_busy            (sb_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
  endfunction
  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
  endfunction
  function automatic logic [31:0] enc_lw(input int rd, input int rs1, input int imm);
    return (32'(imm) << 20) | (32'(rs1) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
  endfunction
  function automatic logic [31:0] enc_jal(input int rd);
    return (32'(rd) << 7) | 32'h6f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entries(input logic [31:0] i0, input logic [31:0] a0,
                             input logic [31:0] i1, input logic [31:0] a1,
                             input logic [3:0] cnt);
    entry0_instruction = i0;
    entry0_address     = a0;
    entry1_instruction = i1;
    entry1_address     = a1;
    entry_count        = cnt;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
    set_entries(enc_addi(1, 0, 5), 32'h100, enc_add(2, 3, 4), 32'h104, 4'd2);
    check("rst_pop0", 64'(pop0), 64'd0);
    check("rst_slot0_valid", 64'(slot0_valid), 64'd0);
    check("rst_sb_busy", 64'(sb_busy), 64'd0);
    step();
    rst = 1'b0;
    #1;

    // independent pair
    check("pair_pop0", 64'(pop0), 64'd1);
    check("pair_pop1", 64'(pop1), 64'd1);
    step();
    check("pair_slot0_valid", 64'(slot0_valid), 64'd1);
    check("pair_slot0_pc", 64'(slot0_pc), 64'h100);
    check("pair_slot1_valid", 64'(slot1_valid), 64'd1);
    check("pair_slot1_pc", 64'(slot1_pc), 64'h104);
    check("pair_slot1_instr", 64'(slot1_instr), 64'(enc_add(2, 3, 4)));

    // intra-pair RAW
    set_entries(enc_addi(5, 0, 1), 32'h108, enc_add(6, 5, 5), 32'h10c, 4'd2);
    check("raw_pop0", 64'(pop0), 64'd1);
    check("raw_pop1", 64'(pop1), 64'd0);
    step();
    check("raw_slot1_valid", 64'(slot1_valid), 64'd0);
    check("raw_slot1_instr", 64'(slot1_instr), 64'd0);
    set_entries(enc_add(6, 5, 5), 32'h10c, 32'h0, 32'h0, 4'd1);
    check("raw_next_pop0", 64'(pop0), 64'd1);
    check("cnt1_pop1", 64'(pop1), 64'd0);
    step();
    check("raw_next_slot0_pc", 64'(slot0_pc), 64'h10c);

    // pairing restrictions
    set_entries(enc_jal(1), 32'h110, enc_addi(10, 0, 1), 32'h114, 4'd2);
    check("jal_pair_pop1", 64'(pop1), 64'd0);
    set_entries(enc_addi(1, 0, 1), 32'h110, enc_lw(11, 2, 0), 32'h114, 4'd2);
    check("nonalu_pop1", 64'(pop1), 64'd0);
    set_entries(enc_addi(12, 0, 1), 32'h110, enc_addi(12, 0, 2), 32'h114, 4'd2);
    check("waw_pop1", 64'(pop1), 64'd0);
    set_entries(enc_addi(12, 0, 1), 32'h110, enc_addi(13, 0, 2), 32'h114, 4'd0);
    check("cnt0_pop0", 64'(pop0), 64'd0);

    // load-use
    set_entries(enc_lw(7, 1, 0), 32'h200, enc_add(8, 7, 0), 32'h204, 4'd2);
    check("lu_pop0", 64'(pop0), 64'd1);
    check("lu_pop1", 64'(pop1), 64'd0);
    step();
    check("lu_sb_busy", 64'(sb_busy), 64'h80);
    set_entries(enc_add(8, 7, 0), 32'h204, 32'h0, 32'h0, 4'd1);
    check("lu_blocked", 64'(pop0), 64'd0);
    step();
    check("lu_blocked2", 64'(pop0), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1;
    check("lu_no_bypass", 64'(pop0), 64'd0);
    step();
    wb_valid = 1'b0;
    #1;
    check("lu_sb_cleared", 64'(sb_busy), 64'd0);
    check("lu_pop_after_wb", 64'(pop0), 64'd1);
    step();
    check("lu_slot0_pc", 64'(slot0_pc), 64'h204);

    // set/clear collision
    set_entries(enc_lw(9, 2, 0), 32'h300, 32'h0, 32'h0, 4'd1);
    wb_valid = 1'b1; wb_rd = 5'd9;
    #1;
    check("coll_pop0", 64'(pop0), 64'd1);
    step();
    wb_valid = 1'b0;
    check("coll_sb_busy", 64'(sb_busy), 64'h200);

    // backpressure
    set_entries(enc_addi(1, 0, 3), 32'h400, 32'h0, 32'h0, 4'd1);
    step();
    check("bp_slot0_pc_pre", 64'(slot0_pc), 64'h400);
    set_entries(enc_addi(2, 0, 4), 32'h404, 32'h0, 32'h0, 4'd1);
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_pop0", 64'(pop0), 64'd0);
      step();
      check("bp_slot0_valid", 64'(slot0_valid), 64'd1);
      check("bp_slot0_pc", 64'(slot0_pc), 64'h400);
    end

    // flush dominates issue_ready
    issue_ready = 1'b1; flush = 1'b1;
    #1;
    check("fl_pop0", 64'(pop0), 64'd0);
    step();
    check("fl_slot0_valid", 64'(slot0_valid), 64'd0);
    check("fl_slot1_valid", 64'(slot1_valid), 64'd0);
    check("fl_sb_busy", 64'(sb_busy), 64'h200);
    flush = 1'b0;

    // asynchronous reset mid-operation
    set_entries(enc_addi(1, 0, 5), 32'h500, enc_add(2, 3, 4), 32'h504, 4'd2);
    step();
    check("ar_pre_slot1_valid", 64'(slot1_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_slot0_valid", 64'(slot0_valid), 64'd0);
    check("ar_slot1_valid", 64'(slot1_valid), 64'd0);
    check("ar_slot0_pc", 64'(slot0_pc), 64'd0);
    check("ar_sb_busy", 64'(sb_busy), 64'd0);
    check("ar_pop0", 64'(pop0), 64'd0);
    step();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
